// File: rtl/logic_serial_engine_pkg.sv
// Shared opcode constants, FSM encoding and sizing helper for the bit-serial logic engine.
package logic_serial_engine_pkg;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_NOR = 2'b10;
  localparam logic [1:0] LOGIC_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Step counter is never narrower than one bit, even for a single-step engine.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/logic_slice1.sv
// One-bit combinational logic slice; the engine instantiates LANES of these.
module logic_slice1
  import logic_serial_engine_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  // Opcode decode for a single bit position
  always_comb begin
    y = 1'b0;
    case (op)
      LOGIC_AND: y = a & b;
      LOGIC_OR:  y = a | b;
      LOGIC_NOR: y = ~(a | b);
      LOGIC_XOR: y = a ^ b;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_serial_engine.sv
// Bit-serial AND/OR/NOR/XOR engine: LANES bits per cycle, LSB first, with valid/ready on both sides.
module logic_serial_engine
  import logic_serial_engine_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             busy
);

  localparam int STEPS = WIDTH / LANES;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  if (LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("logic_serial_engine: LANES must divide WIDTH");
  end

  state_e             state_r;
  state_e             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   acc_r;
  logic               zero_acc_r;
  logic [CW-1:0]      cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [WIDTH-1:0]   out_result_r;
  logic               out_zero_r;

  logic [LANES-1:0]       slice_y_s;
  logic [WIDTH+LANES-1:0] acc_cat_s;
  logic [WIDTH-1:0]       acc_next_s;
  logic                   zero_next_s;
  logic                   last_step_s;
  logic                   accept_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic_slice1 u_slice (
      .a  (a_r[g]),
      .b  (b_r[g]),
      .op (op_r),
      .y  (slice_y_s[g])
    );
  end

  // Slice outputs enter from the top so the first chunk ends up at bit 0 after STEPS shifts.
  assign acc_cat_s   = {slice_y_s, acc_r};
  assign acc_next_s  = acc_cat_s[WIDTH+LANES-1:LANES];
  assign zero_next_s = zero_acc_r & ~(|slice_y_s);
  assign last_step_s = (cnt_r == LAST_CNT);

  // Next-state and handshake decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Operand shifters, accumulators and held result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
      acc_r        <= {WIDTH{1'b0}};
      zero_acc_r   <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      out_result_r <= {WIDTH{1'b0}};
      out_zero_r   <= 1'b0;
    end else if (accept_s) begin
      a_r        <= in_a;
      b_r        <= in_b;
      op_r       <= in_op;
      acc_r      <= {WIDTH{1'b0}};
      zero_acc_r <= 1'b1;
      cnt_r      <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_r        <= a_r >> LANES;
      b_r        <= b_r >> LANES;
      acc_r      <= acc_next_s;
      zero_acc_r <= zero_next_s;
      if (last_step_s) begin
        cnt_r        <= {CW{1'b0}};
        out_result_r <= acc_next_s;
        out_zero_r   <= zero_next_s;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_result = out_result_r;
  assign out_zero   = out_zero_r;

endmodule
